// File: rtl/result_bcd_conv_pkg.sv
// Shared constants and types for the binary-to-BCD result converter.
// State codes 2'b10/2'b11 are reserved and behave as IDLE.
package result_bcd_conv_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_DIGITS     = 3;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01
    } state_t;

endpackage

// File: rtl/result_bcd_conv_if.sv
// Start/Busy/Done handshake and data bus between the adder datapath and the BCD converter.
interface result_bcd_conv_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  Start;
    logic [WIDTH-1:0]      BinIn;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   BcdOut;

    modport master (output Start, output BinIn, input Busy, input Done, input BcdOut);
    modport slave  (input Start, input BinIn, output Busy, output Done, output BcdOut);
endinterface

// File: rtl/result_bcd_conv_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import result_bcd_conv_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // 4-bit add with no carry out; inputs never exceed 9 in a valid conversion
    assign digit_o = (digit_i >= 4'(BCD_ADJ_THRESH)) ? (digit_i + 4'(BCD_ADJ_ADD)) : digit_i;

endmodule

// File: rtl/result_bcd_conv.sv
// Sequential double-dabble converter: captures an adder result on Start and
// produces packed BCD digits after WIDTH shift cycles, one bit per clock.
module result_bcd_conv
    import result_bcd_conv_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic             CLK,
    input  logic             RST,
    result_bcd_conv_if.slave bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   adj_c;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (sr_q[WIDTH + 4*g +: 4]),
            .digit_o (adj_c[4*g +: 4])
        );
    end

    // Adjusted BCD half plus binary half, shifted left; the top bit falls off
    assign sr_d = {adj_c[BCD_W-2:0], sr_q[WIDTH-1:0], 1'b0};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        bcd_q   <= sr_d[SR_W-1:WIDTH];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (bus.Start) begin
                        sr_q    <= {BCD_W'(0), bus.BinIn};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
            endcase
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.BcdOut = bcd_q;

endmodule
